move_query_scheduler: RTL and testbench

//  Shares the single-port map block RAM among pacman and the ghosts for valid-move lookups.

---
 rtl/move_query_scheduler_if.sv | 32 +++
 rtl/move_query_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_move_query_scheduler.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/move_query_scheduler_if.sv
// Bundle between the move-query scheduler, its requesters and the map RAM.
// Latency: n/a (wires only).
// Backpressure: none; the requester side holds req level until done carries its id.
// Ports: req/pos_* come from the movement controllers, map_* go to and from the map RAM,
//        and busy/done/done_id/valid_moves return the result.
// Modports: slave = scheduler side; master = requester + RAM side.
interface move_query_scheduler_if #(
  parameter int NUM_REQ = 5,
  parameter int ID_W    = 3,
  parameter int ADDR_W  = 11
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*11-1:0] pos_x_flat;
  logic [NUM_REQ*10-1:0] pos_y_flat;
  logic                  map_rd_en;
  logic [ADDR_W-1:0]     map_addr;
  logic                  map_rd_data;
  logic                  busy;
  logic                  done;
  logic [ID_W-1:0]       done_id;
  logic [3:0]            valid_moves;

  modport slave (
    input  req, pos_x_flat, pos_y_flat, map_rd_data,
    output map_rd_en, map_addr, busy, done, done_id, valid_moves
  );

  modport master (
    output req, pos_x_flat, pos_y_flat, map_rd_data,
    input  map_rd_en, map_addr, busy, done, done_id, valid_moves
  );
endinterface

// File: rtl/move_query_scheduler.sv
// Round-robin shares the single-port map RAM among pacman and ghosts for valid-move lookups.
// Latency: req sampled in IDLE at cycle 0 -> done pulse at cycle 5+RAM_LAT.
// Backpressure: none; requesters hold req until done with their id, one query in flight.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries req, pos_x_flat, pos_y_flat,
//        map_rd_en, map_addr, map_rd_data, busy, done, done_id, valid_moves.
module move_query_scheduler #(
  parameter int NUM_REQ    = 5,
  parameter int ID_W       = 3,
  parameter int TILE_SHIFT = 4,
  parameter int MAP_W      = 40,
  parameter int MAP_H      = 30,
  parameter int ADDR_W     = 11,
  parameter int RAM_LAT    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  move_query_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   gnt_id_q;
  logic [ID_W-1:0]   done_id_q;
  logic [10:0]       tile_x_q;
  logic [9:0]        tile_y_q;
  logic [1:0]        slot_q;
  logic [3:0]        acc_q;
  logic [3:0]        moves_q;
  logic [ADDR_W-1:0] addr_hold_q;

  // One entry per outstanding slot: issued flag, real-read flag and slot number,
  // delayed by RAM_LAT so the tail lines up with the RAM data.
  logic [RAM_LAT-1:0] pipe_vld_q;
  logic [RAM_LAT-1:0] pipe_rd_q;
  logic [1:0]         pipe_slot_q [RAM_LAT];

  // Round-robin search starting just after the last winner.
  logic            arb_found;
  logic [ID_W-1:0] arb_id;
  always_comb begin
    int idx;
    idx       = 0;
    arb_found = 1'b0;
    arb_id    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!arb_found && bus.req[idx]) begin
        arb_found = 1'b1;
        arb_id    = ID_W'(idx);
      end
    end
  end

  logic [10:0] sel_x;
  logic [9:0]  sel_y;
  assign sel_x = bus.pos_x_flat[int'(arb_id)*11 +: 11];
  assign sel_y = bus.pos_y_flat[int'(arb_id)*10 +: 10];

  // Neighbour for the current slot; edge slots keep their cycle but never read.
  logic              off_map;
  logic              slot_edge;
  logic [ADDR_W-1:0] nb_x, nb_y;
  logic              slot_rd;
  logic [ADDR_W-1:0] slot_addr;

  assign off_map = (tile_x_q >= 11'(MAP_W)) || (tile_y_q >= 10'(MAP_H));

  always_comb begin
    slot_edge = 1'b0;
    nb_x      = ADDR_W'(tile_x_q);
    nb_y      = ADDR_W'(tile_y_q);
    case (slot_q)
      2'd0: begin
        slot_edge = (tile_x_q == 11'(MAP_W - 1));
        nb_x      = ADDR_W'(tile_x_q) + ADDR_W'(1);
      end
      2'd1: begin
        slot_edge = (tile_y_q == '0);
        nb_y      = ADDR_W'(tile_y_q) - ADDR_W'(1);
      end
      2'd2: begin
        slot_edge = (tile_y_q == 10'(MAP_H - 1));
        nb_y      = ADDR_W'(tile_y_q) + ADDR_W'(1);
      end
      default: begin
        slot_edge = (tile_x_q == '0);
        nb_x      = ADDR_W'(tile_x_q) - ADDR_W'(1);
      end
    endcase
  end

  assign slot_rd   = (state_q == ISSUE) && !off_map && !slot_edge;
  assign slot_addr = nb_y * ADDR_W'(MAP_W) + nb_x;

  // Capture at the pipe tail; suppressed slots leave their cleared bit at 0.
  logic       tail_vld;
  logic       tail_rd;
  logic [1:0] tail_slot;
  logic       last_cap;
  logic [3:0] acc_next;

  assign tail_vld  = pipe_vld_q[RAM_LAT-1];
  assign tail_rd   = pipe_rd_q[RAM_LAT-1];
  assign tail_slot = pipe_slot_q[RAM_LAT-1];
  assign last_cap  = tail_vld && (tail_slot == 2'd3);

  always_comb begin
    acc_next = acc_q;
    if (tail_vld && tail_rd) acc_next[tail_slot] = ~bus.map_rd_data;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_found) state_d = ISSUE;
      ISSUE:   if (slot_q == 2'd3) state_d = WAIT;
      WAIT:    if (last_cap) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      gnt_id_q    <= '0;
      done_id_q   <= '0;
      tile_x_q    <= '0;
      tile_y_q    <= '0;
      slot_q      <= '0;
      acc_q       <= '0;
      moves_q     <= '0;
      addr_hold_q <= '0;
      pipe_vld_q  <= '0;
      pipe_rd_q   <= '0;
      for (int i = 0; i < RAM_LAT; i++) pipe_slot_q[i] <= '0;
    end else begin
      state_q <= state_d;

      pipe_vld_q[0]  <= (state_q == ISSUE);
      pipe_rd_q[0]   <= slot_rd;
      pipe_slot_q[0] <= slot_q;
      for (int i = 1; i < RAM_LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_rd_q[i]   <= pipe_rd_q[i-1];
        pipe_slot_q[i] <= pipe_slot_q[i-1];
      end

      if (state_q == IDLE && arb_found) begin
        gnt_id_q <= arb_id;
        rr_ptr_q <= arb_id;
        tile_x_q <= sel_x >> TILE_SHIFT;
        tile_y_q <= sel_y >> TILE_SHIFT;
        slot_q   <= '0;
        acc_q    <= '0;
      end else begin
        acc_q <= acc_next;
      end

      if (state_q == ISSUE) slot_q <= slot_q + 2'd1;
      if (slot_rd) addr_hold_q <= slot_addr;

      if (state_q == WAIT && last_cap) begin
        moves_q   <= acc_next;
        done_id_q <= gnt_id_q;
      end
    end
  end

  assign bus.map_rd_en   = slot_rd;
  assign bus.map_addr    = slot_rd ? slot_addr : addr_hold_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.done_id     = done_id_q;
  assign bus.valid_moves = moves_q;

endmodule

// File: tb/tb_move_query_scheduler.sv
// Scoreboard bench: stimulus pushes expected reads/results from a tile-level model,
// a negedge monitor pops and compares; a second RAM_LAT=3 instance gets a directed query.
module tb_move_query_scheduler;
  localparam int NR  = 5;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  move_query_scheduler_if #(.NUM_REQ(NR), .ID_W(3), .ADDR_W(11)) bus ();
  move_query_scheduler_if #(.NUM_REQ(NR), .ID_W(3), .ADDR_W(11)) bus3 ();

  move_query_scheduler #(.RAM_LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));
  move_query_scheduler #(.RAM_LAT(3))   dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // Map RAM models
  logic       mem [0:2047];
  logic       rd1 = 1'b0;
  logic [2:0] rd3 = 3'b000;
  always @(posedge clk) begin
    if (bus.map_rd_en) rd1 <= mem[bus.map_addr];
    rd3 <= {rd3[1:0], mem[bus3.map_addr]};
  end
  assign bus.map_rd_data  = rd1;
  assign bus3.map_rd_data = rd3[2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int id;
    int moves;
    int due;
  } exp_t;

  exp_t done_q[$];
  int   addr_q[$];
  int   n_done = 0;
  int   rr     = NR - 1;

  logic [10:0] px [NR];
  logic [9:0]  py [NR];

  // Monitor
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (bus.map_rd_en) begin
        if (addr_q.size() == 0) chk("unexpected_read", int'(bus.map_addr), -1);
        else chk("map_addr", int'(bus.map_addr), addr_q.pop_front());
      end
      if (bus.done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", int'(bus.done_id), -1);
        end else begin
          e = done_q.pop_front();
          chk("done_id", int'(bus.done_id), e.id);
          chk("valid_moves", int'(bus.valid_moves), e.moves);
          chk("done_cycle", cyc, e.due);
          chk("busy_at_done", int'(bus.busy), 1);
          chk("reads_missing", addr_q.size(), 0);
        end
        n_done++;
      end
    end
  end

  task automatic drive_pos();
    for (int i = 0; i < NR; i++) begin
      bus.pos_x_flat[i*11 +: 11] = px[i];
      bus.pos_y_flat[i*10 +: 10] = py[i];
    end
  endtask

  function automatic logic [10:0] rand_x();
    case ($urandom_range(0, 5))
      0:       return 11'($urandom_range(0, 15));
      1:       return 11'($urandom_range(624, 639));
      2:       return 11'($urandom_range(640, 2047));
      default: return 11'($urandom_range(0, 639));
    endcase
  endfunction

  function automatic logic [9:0] rand_y();
    case ($urandom_range(0, 5))
      0:       return 10'($urandom_range(0, 15));
      1:       return 10'($urandom_range(464, 479));
      2:       return 10'($urandom_range(480, 1023));
      default: return 10'($urandom_range(0, 479));
    endcase
  endfunction

  task automatic rand_pos();
    for (int i = 0; i < NR; i++) begin
      px[i] = rand_x();
      py[i] = rand_y();
    end
    drive_pos();
  endtask

  task automatic fill_mem(input int wall_pct);
    for (int a = 0; a < 2048; a++)
      mem[a] = ($urandom_range(0, 99) < wall_pct) ? 1'b1 : 1'b0;
  endtask

  // Issue while the DUT is idle; c0 is the cycle in which req is sampled.
  task automatic issue(input logic [NR-1:0] mask, input int c0);
    int dx [4] = '{1, 0, 0, -1};
    int dy [4] = '{0, -1, 1, 0};
    int w, tx, ty, nx, ny, mv;
    exp_t e;
    bus.req = mask;
    drive_pos();
    w = -1;
    for (int i = 1; i <= NR; i++)
      if (w < 0 && mask[(rr + i) % NR]) w = (rr + i) % NR;
    rr = w;
    tx = int'(px[w]) / 16;
    ty = int'(py[w]) / 16;
    mv = 0;
    if (tx < 40 && ty < 30) begin
      for (int k = 0; k < 4; k++) begin
        nx = tx + dx[k];
        ny = ty + dy[k];
        if (nx >= 0 && nx < 40 && ny >= 0 && ny < 30) begin
          addr_q.push_back(ny * 40 + nx);
          if (!mem[ny * 40 + nx]) mv = mv | (1 << k);
        end
      end
    end
    e.id    = w;
    e.moves = mv;
    e.due   = c0 + 5 + LAT;
    done_q.push_back(e);
  endtask

  // Wait for the next done, then step one cycle into IDLE and check busy dropped.
  task automatic wait_done();
    int start;
    int k;
    start = n_done;
    k = 0;
    while (n_done == start && k < 60) begin
      @(negedge clk); #1;
      k++;
    end
    if (n_done == start) begin
      chk("done_timeout", 0, 1);
      addr_q.delete();
      done_q.delete();
    end
    @(negedge clk); #1;
    chk("busy_after_done", int'(bus.busy), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_done_id"}, int'(bus.done_id), 0);
    chk({tag, "_valid_moves"}, int'(bus.valid_moves), 0);
    chk({tag, "_map_rd_en"}, int'(bus.map_rd_en), 0);
    chk({tag, "_map_addr"}, int'(bus.map_addr), 0);
  endtask

  initial begin
    int l3_addr [$];
    int want3 [4] = '{206, 165, 245, 204};
    int c0, dcyc, did, dmv;

    rst = 1'b1;
    bus.req = '0;
    bus3.req = '0;
    bus3.pos_x_flat = '0;
    bus3.pos_y_flat = '0;
    for (int i = 0; i < NR; i++) begin
      px[i] = '0;
      py[i] = '0;
    end
    drive_pos();
    for (int a = 0; a < 2048; a++) mem[a] = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk); #1;

    // All-free map, pacman at (80,80)
    px[0] = 11'd80; py[0] = 10'd80;
    issue(5'b00001, cyc);
    wait_done();

    // Walls right and left of tile (5,5)
    mem[206] = 1'b1;
    mem[204] = 1'b1;
    issue(5'b00001, cyc);
    wait_done();

    // Top-left corner: only right and down are read
    for (int a = 0; a < 2048; a++) mem[a] = 1'b0;
    px[0] = 11'd0; py[0] = 10'd0;
    issue(5'b00001, cyc);
    wait_done();

    // Reset during slot 2 aborts the query
    fill_mem(30);
    px[0] = 11'd80; py[0] = 10'd80;
    issue(5'b00001, cyc);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    bus.req = '0;
    @(negedge clk); #1;
    chk_zero("midreset");
    addr_q.delete();
    done_q.delete();
    rr = NR - 1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;

    // All requesters held high: round-robin order, positions scrambled after each grant
    for (int q = 0; q < 6; q++) begin
      rand_pos();
      issue(5'b11111, cyc);
      @(negedge clk); #1;
      rand_pos();
      wait_done();
    end
    bus.req = '0;

    // Random masks, positions, maps, req drops
    for (int q = 0; q < 150; q++) begin
      if (q % 10 == 0) fill_mem($urandom_range(0, 60));
      rand_pos();
      issue(NR'($urandom_range(1, 31)), cyc);
      @(negedge clk); #1;
      if ($urandom_range(0, 1) == 1) bus.req[rr] = 1'b0;
      rand_pos();
      wait_done();
      bus.req = '0;
    end

    // RAM_LAT=3 instance, all-free map, pacman at (80,80)
    for (int a = 0; a < 2048; a++) mem[a] = 1'b0;
    bus3.pos_x_flat[10:0] = 11'd80;
    bus3.pos_y_flat[9:0]  = 10'd80;
    c0 = cyc;
    bus3.req = 5'b00001;
    dcyc = -1; did = -1; dmv = -1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (bus3.map_rd_en) l3_addr.push_back(int'(bus3.map_addr));
      if (bus3.done && dcyc < 0) begin
        dcyc = cyc;
        did  = int'(bus3.done_id);
        dmv  = int'(bus3.valid_moves);
        bus3.req = '0;
      end
    end
    chk("lat3_nreads", l3_addr.size(), 4);
    for (int k = 0; k < 4; k++)
      chk("lat3_addr", (k < l3_addr.size()) ? l3_addr[k] : -1, want3[k]);
    chk("lat3_done_cycle", dcyc, c0 + 8);
    chk("lat3_done_id", did, 0);
    chk("lat3_valid_moves", dmv, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
